mem_read_arbiter: RTL

Shares the single AXI read channel between the instruction cache and the data cache. It accepts line-refill (128-bit, 4-beat) and uncached (single-word) read requests, grants one requester at a time and drives the AR channel. It then assembles the R beats into a 128-bit line and returns it to the granted cache with the `*_rvalid` pulse. It sits between the two caches and the AXI bridge. Only one transaction is outstanding at a time.

---
 rtl/mem_read_arbiter_if.sv | 64 ++++++
 rtl/mem_read_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_read_arbiter_if
//   Bundles the two cache read ports and the AXI AR/R channel seen by
//   mem_read_arbiter.
//
//   modport master : the arbiter. It drives the AXI read address channel and
//                    returns lines and handshake pulses to the caches.
//   modport slave  : the surroundings (icache, dcache, AXI bridge).
//
//   Signals
//     i_ren / i_raddr              icache request, held until i_ren_received
//     i_ren_received               pulse: icache request accepted on AR
//     i_rvalid / i_rdata           pulse + 128-bit icache refill line
//     i_flush_flag_valid           icache transaction in flight
//     d_ren / d_raddr / d_uncache  dcache request (d_uncache = single word)
//     d_ren_received               pulse: dcache request accepted on AR
//     d_rvalid / d_rdata           pulse + dcache line (uncached word in [31:0])
//     arvalid .. arid, arready     AXI read address channel
//     rvalid, rdata, rlast, rready AXI read data channel
// -----------------------------------------------------------------------------
interface mem_read_arbiter_if;
    logic         i_ren;
    logic [31:0]  i_raddr;
    logic         i_ren_received;
    logic         i_rvalid;
    logic [127:0] i_rdata;
    logic         i_flush_flag_valid;

    logic         d_ren;
    logic [31:0]  d_raddr;
    logic         d_uncache;
    logic         d_ren_received;
    logic         d_rvalid;
    logic [127:0] d_rdata;

    logic         arvalid;
    logic         arready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [3:0]   arid;

    logic         rvalid;
    logic         rready;
    logic [31:0]  rdata;
    logic         rlast;

    modport master (
        input  i_ren, i_raddr, d_ren, d_raddr, d_uncache,
        input  arready, rvalid, rdata, rlast,
        output i_ren_received, i_rvalid, i_rdata, i_flush_flag_valid,
        output d_ren_received, d_rvalid, d_rdata,
        output arvalid, araddr, arlen, arsize, arburst, arid, rready
    );

    modport slave (
        output i_ren, i_raddr, d_ren, d_raddr, d_uncache,
        output arready, rvalid, rdata, rlast,
        input  i_ren_received, i_rvalid, i_rdata, i_flush_flag_valid,
        input  d_ren_received, d_rvalid, d_rdata,
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// mem_read_arbiter
//   Shares one AXI read channel between the icache and the dcache. One
//   transaction is outstanding at a time: a request is granted in IDLE
//   (round-robin on a tie), presented on AR, and the R beats are assembled
//   into a 128-bit line that is handed back to the owner with a one-cycle
//   *_rvalid pulse. A transaction, once accepted, is always completed.
//
//   Ports
//     clk   : clock
//     rst   : synchronous, active-high reset
//     bus   : mem_read_arbiter_if.master (cache request/response + AXI AR/R)
// -----------------------------------------------------------------------------
module mem_read_arbiter (
    input  logic               clk,
    input  logic               rst,
    mem_read_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic         owner_q, owner_d;           // 0 = icache, 1 = dcache
    logic         uncache_q, uncache_d;
    logic         last_grant_q, last_grant_d; // owner of the previous grant
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] line_q, line_d;
    logic [127:0] i_rdata_q, i_rdata_d;
    logic [127:0] d_rdata_q, d_rdata_d;
    logic         i_rvalid_q, i_rvalid_d;
    logic         d_rvalid_q, d_rvalid_d;

    logic         req_any_s;
    logic         grant_d_s;
    logic         ar_hs_s;
    logic         r_beat_s;
    logic         r_done_s;
    logic [127:0] line_beat_s;

    // Request arbitration, handshake decode and line-with-current-beat merge
    always_comb begin
        req_any_s = bus.i_ren || bus.d_ren;
        ar_hs_s   = (state_q == ST_AR) && bus.arready;
        r_beat_s  = (state_q == ST_R) && bus.rvalid;
        r_done_s  = r_beat_s && bus.rlast;
        // On a tie the requester that did not win last time gets the channel.
        if (bus.i_ren && bus.d_ren) begin
            grant_d_s = ~last_grant_q;
        end else begin
            grant_d_s = bus.d_ren;
        end
        line_beat_s = line_q;
        line_beat_s[{cnt_q, 5'd0} +: 32] = bus.rdata;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_d = ST_AR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                if (bus.arready) begin
                    state_d = ST_R;
                end else begin
                    state_d = ST_AR;
                end
            end
            ST_R: begin
                if (r_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_R;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: latched request, beat counter, line buffer, results
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= 32'd0;
            owner_q      <= 1'b0;
            uncache_q    <= 1'b0;
            last_grant_q <= 1'b0;
            cnt_q        <= 2'd0;
            line_q       <= 128'd0;
            i_rdata_q    <= 128'd0;
            d_rdata_q    <= 128'd0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            owner_q      <= owner_d;
            uncache_q    <= uncache_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
        end
    end

    // Datapath next-state: latch on grant, assemble beats, hand over on rlast
    always_comb begin
        addr_d       = addr_q;
        owner_d      = owner_q;
        uncache_d    = uncache_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        if ((state_q == ST_IDLE) && req_any_s) begin
            owner_d      = grant_d_s;
            last_grant_d = grant_d_s;
            cnt_d        = 2'd0;
            // Cleared so that beats an uncached burst never writes read as 0.
            line_d       = 128'd0;
            if (grant_d_s) begin
                addr_d    = bus.d_raddr;
                uncache_d = bus.d_uncache;
            end else begin
                addr_d    = bus.i_raddr;
                uncache_d = 1'b0;
            end
        end else if (r_beat_s) begin
            line_d = line_beat_s;
            if (bus.rlast) begin
                cnt_d = 2'd0;
                if (owner_q) begin
                    d_rdata_d  = line_beat_s;
                    d_rvalid_d = 1'b1;
                end else begin
                    i_rdata_d  = line_beat_s;
                    i_rvalid_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end else begin
            line_d = line_q;
        end
    end

    // FSM outputs: AR fields only while presenting, R ready, handshake pulses
    always_comb begin
        bus.arsize  = 3'b010;
        bus.arburst = 2'b01;
        if (state_q == ST_AR) begin
            bus.arvalid = 1'b1;
            bus.arid    = {3'b000, owner_q};
            if (uncache_q) begin
                bus.araddr = addr_q;
                bus.arlen  = 8'd0;
            end else begin
                bus.araddr = {addr_q[31:4], 4'b0000};
                bus.arlen  = 8'd3;
            end
        end else begin
            bus.arvalid = 1'b0;
            bus.arid    = 4'd0;
            bus.araddr  = 32'd0;
            bus.arlen   = 8'd0;
        end
        bus.rready         = (state_q == ST_R);
        bus.i_ren_received = ar_hs_s && !owner_q;
        bus.d_ren_received = ar_hs_s && owner_q;
        // In flight from acceptance up to, but excluding, the i_rvalid cycle.
        bus.i_flush_flag_valid = !owner_q && (ar_hs_s || (state_q == ST_R));
        bus.i_rvalid = i_rvalid_q;
        bus.i_rdata  = i_rdata_q;
        bus.d_rvalid = d_rvalid_q;
        bus.d_rdata  = d_rdata_q;
    end

endmodule
